pipe_hazard_ctrl: RTL and testbench
===================================

// Module: pipe_hazard_ctrl
// PURPOSE
// - Drives the enable/flush side of the pipeline registers (IF/ID, ID/EX, EX/MEM) and the PC enable.
// - Sits beside the ID/EX stage and consumes EX-stage fields: MemRead, destination register, branch/jump redirect.
// - Produces load-use bubbles, redirect flushes and data-memory wait freezes.
// - A registered FSM guarantees exactly one bubble per load-use hazard and a bounded memory wait.
// PARAMETERS
// - MEM_TIMEOUT  15  max cycles spent in MEM_WAIT before forced release (1..255)
// - CNT_WIDTH    16  width of the performance counters (HAZ_PERF_CNT_EN only)
// PORTS
// - clk            in   1   rising-edge clock
// - reset          in   1   synchronous reset, active-low (0 = reset)
// - MemReadEX      in   1   instruction in EX is a load
// - WriteRegAddrEX in   5   rd of instruction in EX
// - Reg1AddrID     in   5   rs1 of instruction in ID
// - Reg2AddrID     in   5   rs2 of instruction in ID
// - Use1ID         in   1   ID instruction reads rs1
// - Use2ID         in   1   ID instruction reads rs2
// - BranchTakenEX  in   1   taken branch / JAL / JALR resolved in EX
// - MemReqM        in   1   load/store active in MEM
// - MemReadyM      in   1   data memory completes the access this cycle
// - PCEnable       out  1   PC register update enable
// - IFIDEnable     out  1   IF/ID register enable
// - IFIDFlush      out  1   IF/ID register clears to NOP
// - IDEXEnable     out  1   ID/EX register enable
// - IDEXFlush      out  1   ID/EX control fields clear (bubble)
// - EXMEMEnable    out  1   EX/MEM register enable
// - MemTimeout     out  1   one-cycle pulse on forced MEM_WAIT release
// - HazState       out  2   current FSM state (RUN=0, LOAD_STALL=1, MEM_WAIT=2)
// - StallCycles    out  CNT_WIDTH  count of frozen/bubble cycles
// - FlushCount     out  CNT_WIDTH  count of redirect flushes
// BEHAVIOUR
// - State register and wait counter are registered. Control outputs decode combinationally from state + inputs, so they act in the same cycle.
// - Reset (reset=0 at a clk edge): state=RUN, wait counter=0, counters=0, MemTimeout=0.
//   - While reset=0, all enables are 0 and IFIDFlush=IDEXFlush=1.
//   - Reset mid-stall abandons the stall immediately.
// - Hazard definitions:
//   - memstall = MemReqM & ~MemReadyM
//   - loaduse = MemReadEX & (WriteRegAddrEX!=0) & ((Use1ID & Reg1AddrID==WriteRegAddrEX) | (Use2ID & Reg2AddrID==WriteRegAddrEX))
// - Defaults: all enables 1, all flushes 0.
// - RUN, priority memstall > BranchTakenEX > loaduse:
//   - memstall: all enables 0, no flush; next state MEM_WAIT, counter <= 1.
//   - BranchTakenEX: IFIDFlush=1, IDEXFlush=1, PC loads target; stay in RUN. A coincident load-use is discarded.
//   - loaduse: PCEnable=0, IFIDEnable=0, IDEXFlush=1 (one bubble); next state LOAD_STALL.
// - LOAD_STALL (exactly one cycle):
//   - loaduse is not re-evaluated; defaults apply.
//   - BranchTakenEX cannot occur here because EX holds the bubble.
//   - memstall is handled exactly as in RUN.
//   - Next state is RUN unless memstall.
// - MEM_WAIT:
//   - All enables 0 while MemReadyM=0.
//   - MemReadyM=1: enables 1 this cycle; next state RUN; counter <= 0.
//   - counter==MEM_TIMEOUT with MemReadyM=0: MemTimeout=1, enables 1, next state RUN.
//   - Otherwise counter increments.
//   - A BranchTakenEX held during the wait is serviced in RUN on the following cycle; it stays valid because ID/EX is frozen.
// - Counter width is $clog2(MEM_TIMEOUT+1); it never wraps.
// CONFIGURATION
// - HAZ_PERF_CNT_EN defined:
//   - StallCycles increments on every cycle with PCEnable=0 and reset=1.
//   - FlushCount increments on every cycle with IFIDFlush=1 and reset=1.
//   - Both saturate at all-ones.
// - HAZ_PERF_CNT_EN undefined: no counter flops; StallCycles and FlushCount tied to 0; ports remain.
// TESTING
// - Load x5 in EX, ID uses rs1=x5 -> 1 cycle of PCEnable=0, IFIDEnable=0, IDEXFlush=1; HazState 0->1->0; StallCycles=1.
// - Load to x0, ID reads x0 -> no stall; all enables 1.
// - Load-use plus BranchTakenEX in the same cycle -> IFIDFlush=IDEXFlush=1, PCEnable=1; no LOAD_STALL; FlushCount=1.
// - MemReqM=1, MemReadyM low 4 cycles then high -> enables 0 for 4 cycles, 1 on cycle 5, HazState back to 0, MemTimeout never set.
// - MemReadyM never rises, MEM_TIMEOUT=15 -> MemTimeout pulses in the 15th MEM_WAIT cycle; enables 1 that cycle.
// - reset=0 during MEM_WAIT -> next edge HazState=0, flushes 1, enables 0; counters cleared.

Source files
------------

// File: rtl/pipe_hazard_ctrl_if.sv
// Hazard-control bundle between the pipeline datapath and pipe_hazard_ctrl.
// master = pipeline side (drives hazard fields), slave = hazard controller.
interface pipe_hazard_ctrl_if #(
  parameter int CNT_WIDTH = 16
);
  logic                 MemReadEX;
  logic [4:0]           WriteRegAddrEX;
  logic [4:0]           Reg1AddrID;
  logic [4:0]           Reg2AddrID;
  logic                 Use1ID;
  logic                 Use2ID;
  logic                 BranchTakenEX;
  logic                 MemReqM;
  logic                 MemReadyM;
  logic                 PCEnable;
  logic                 IFIDEnable;
  logic                 IFIDFlush;
  logic                 IDEXEnable;
  logic                 IDEXFlush;
  logic                 EXMEMEnable;
  logic                 MemTimeout;
  logic [1:0]           HazState;
  logic [CNT_WIDTH-1:0] StallCycles;
  logic [CNT_WIDTH-1:0] FlushCount;

  modport master (
    output MemReadEX, WriteRegAddrEX, Reg1AddrID, Reg2AddrID, Use1ID, Use2ID,
           BranchTakenEX, MemReqM, MemReadyM,
    input  PCEnable, IFIDEnable, IFIDFlush, IDEXEnable, IDEXFlush, EXMEMEnable,
           MemTimeout, HazState, StallCycles, FlushCount
  );

  modport slave (
    input  MemReadEX, WriteRegAddrEX, Reg1AddrID, Reg2AddrID, Use1ID, Use2ID,
           BranchTakenEX, MemReqM, MemReadyM,
    output PCEnable, IFIDEnable, IFIDFlush, IDEXEnable, IDEXFlush, EXMEMEnable,
           MemTimeout, HazState, StallCycles, FlushCount
  );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: load-use bubbles, redirect flushes, bounded data-memory wait.
// Optional performance counters are built only when HAZ_PERF_CNT_EN is defined.
module pipe_hazard_ctrl #(
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_WIDTH   = 16
) (
  input logic            clk,
  input logic            reset,
  pipe_hazard_ctrl_if.slave hz
);
  localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);

  typedef enum logic [1:0] {
    RUN        = 2'd0,
    LOAD_STALL = 2'd1,
    MEM_WAIT   = 2'd2
  } state_t;

  state_t              state_r;
  logic [WAIT_W-1:0]   wait_cnt_r;
  logic                memstall_s;
  logic                loaduse_s;
  logic                wait_expired_s;
  logic                pc_en_s, ifid_en_s, ifid_fl_s, idex_en_s, idex_fl_s, exmem_en_s, timeout_s;

  // Hazard detection on the current EX/ID/MEM fields.
  always_comb begin
    memstall_s     = hz.MemReqM & ~hz.MemReadyM;
    loaduse_s      = hz.MemReadEX & (hz.WriteRegAddrEX != 5'd0) &
                     ((hz.Use1ID & (hz.Reg1AddrID == hz.WriteRegAddrEX)) |
                      (hz.Use2ID & (hz.Reg2AddrID == hz.WriteRegAddrEX)));
    wait_expired_s = (wait_cnt_r == WAIT_W'(MEM_TIMEOUT));
  end

  // Hazard FSM and memory-wait counter.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_r    <= RUN;
      wait_cnt_r <= {WAIT_W{1'b0}};
    end else begin
      case (state_r)
        RUN: begin
          if (memstall_s) begin
            state_r    <= MEM_WAIT;
            wait_cnt_r <= WAIT_W'(1);
          end else if (hz.BranchTakenEX) begin
            state_r    <= RUN;
          end else if (loaduse_s) begin
            state_r    <= LOAD_STALL;
          end else begin
            state_r    <= RUN;
          end
        end
        LOAD_STALL: begin
          if (memstall_s) begin
            state_r    <= MEM_WAIT;
            wait_cnt_r <= WAIT_W'(1);
          end else begin
            state_r    <= RUN;
          end
        end
        MEM_WAIT: begin
          if (hz.MemReadyM || wait_expired_s) begin
            state_r    <= RUN;
            wait_cnt_r <= {WAIT_W{1'b0}};
          end else begin
            wait_cnt_r <= wait_cnt_r + WAIT_W'(1);
          end
        end
        default: begin
          state_r    <= RUN;
          wait_cnt_r <= {WAIT_W{1'b0}};
        end
      endcase
    end
  end

  // Same-cycle decode of enables/flushes; reset forces a full freeze with NOPs injected.
  always_comb begin
    pc_en_s    = 1'b1;
    ifid_en_s  = 1'b1;
    ifid_fl_s  = 1'b0;
    idex_en_s  = 1'b1;
    idex_fl_s  = 1'b0;
    exmem_en_s = 1'b1;
    timeout_s  = 1'b0;
    if (!reset) begin
      {pc_en_s, ifid_en_s, idex_en_s, exmem_en_s} = 4'b0000;
      {ifid_fl_s, idex_fl_s}                     = 2'b11;
    end else begin
      case (state_r)
        RUN: begin
          if (memstall_s) begin
            {pc_en_s, ifid_en_s, idex_en_s, exmem_en_s} = 4'b0000;
          end else if (hz.BranchTakenEX) begin
            {ifid_fl_s, idex_fl_s} = 2'b11;
          end else if (loaduse_s) begin
            {pc_en_s, ifid_en_s} = 2'b00;
            idex_fl_s            = 1'b1;
          end else begin
            pc_en_s = 1'b1;
          end
        end
        LOAD_STALL: begin
          if (memstall_s) begin
            {pc_en_s, ifid_en_s, idex_en_s, exmem_en_s} = 4'b0000;
          end else begin
            pc_en_s = 1'b1;
          end
        end
        MEM_WAIT: begin
          if (hz.MemReadyM) begin
            pc_en_s = 1'b1;
          end else if (wait_expired_s) begin
            timeout_s = 1'b1;
          end else begin
            {pc_en_s, ifid_en_s, idex_en_s, exmem_en_s} = 4'b0000;
          end
        end
        default: begin
          pc_en_s = 1'b1;
        end
      endcase
    end
  end

  assign hz.PCEnable    = pc_en_s;
  assign hz.IFIDEnable  = ifid_en_s;
  assign hz.IFIDFlush   = ifid_fl_s;
  assign hz.IDEXEnable  = idex_en_s;
  assign hz.IDEXFlush   = idex_fl_s;
  assign hz.EXMEMEnable = exmem_en_s;
  assign hz.MemTimeout  = timeout_s;
  assign hz.HazState    = state_r;

`ifdef HAZ_PERF_CNT_EN
  logic [CNT_WIDTH-1:0] stall_cnt_r;
  logic [CNT_WIDTH-1:0] flush_cnt_r;

  // Saturating counts of frozen/bubble cycles and redirect flushes.
  always_ff @(posedge clk) begin
    if (!reset) begin
      stall_cnt_r <= {CNT_WIDTH{1'b0}};
      flush_cnt_r <= {CNT_WIDTH{1'b0}};
    end else begin
      if (!pc_en_s && (stall_cnt_r != {CNT_WIDTH{1'b1}})) begin
        stall_cnt_r <= stall_cnt_r + CNT_WIDTH'(1);
      end else begin
        stall_cnt_r <= stall_cnt_r;
      end
      if (ifid_fl_s && (flush_cnt_r != {CNT_WIDTH{1'b1}})) begin
        flush_cnt_r <= flush_cnt_r + CNT_WIDTH'(1);
      end else begin
        flush_cnt_r <= flush_cnt_r;
      end
    end
  end

  assign hz.StallCycles = stall_cnt_r;
  assign hz.FlushCount  = flush_cnt_r;
`else
  assign hz.StallCycles = {CNT_WIDTH{1'b0}};
  assign hz.FlushCount  = {CNT_WIDTH{1'b0}};
`endif
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: per-cycle expected control vectors are queued and checked.
module tb_pipe_hazard_ctrl;
  // {PCEnable, IFIDEnable, IFIDFlush, IDEXEnable, IDEXFlush, EXMEMEnable, MemTimeout}
  localparam logic [6:0] OK  = 7'b1101010;
  localparam logic [6:0] FRZ = 7'b0000000;
  localparam logic [6:0] LU  = 7'b0001110;
  localparam logic [6:0] BR  = 7'b1111110;
  localparam logic [6:0] TO  = 7'b1101011;
  localparam logic [6:0] RST = 7'b0010100;

  typedef struct {
    logic [6:0]  ctl;
    logic [1:0]  st;
    logic [15:0] sc;
    logic [15:0] fc;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;
  int   exp_stall = 0;
  int   exp_flush = 0;
  exp_t sb_q[$];

  pipe_hazard_ctrl_if #(.CNT_WIDTH(16)) hz ();

  pipe_hazard_ctrl #(.MEM_TIMEOUT(15), .CNT_WIDTH(16)) dut (
    .clk   (clk),
    .reset (reset),
    .hz    (hz.slave)
  );

  always #5 clk = ~clk;

  task automatic step(input logic rst, input logic mr, input logic [4:0] wr, input logic [4:0] r1,
                      input logic [4:0] r2, input logic u1, input logic u2, input logic br,
                      input logic mq, input logic my, input logic [6:0] ectl, input logic [1:0] est);
    exp_t e;
    exp_t got;
    logic [6:0] act;
    reset             = rst;
    hz.MemReadEX      = mr;
    hz.WriteRegAddrEX = wr;
    hz.Reg1AddrID     = r1;
    hz.Reg2AddrID     = r2;
    hz.Use1ID         = u1;
    hz.Use2ID         = u2;
    hz.BranchTakenEX  = br;
    hz.MemReqM        = mq;
    hz.MemReadyM      = my;
    e.ctl = ectl;
    e.st  = est;
`ifdef HAZ_PERF_CNT_EN
    e.sc  = 16'(exp_stall);
    e.fc  = 16'(exp_flush);
`else
    e.sc  = 16'd0;
    e.fc  = 16'd0;
`endif
    sb_q.push_back(e);
    #2;
    got = sb_q.pop_front();
    act = {hz.PCEnable, hz.IFIDEnable, hz.IFIDFlush, hz.IDEXEnable, hz.IDEXFlush,
           hz.EXMEMEnable, hz.MemTimeout};
    checks += 4;
    assert (act === got.ctl) else begin
      errors++;
      $error("FAIL ctl t=%0t observed=%b expected=%b", $time, act, got.ctl);
    end
    assert (hz.HazState === got.st) else begin
      errors++;
      $error("FAIL state t=%0t observed=%0d expected=%0d", $time, hz.HazState, got.st);
    end
    assert (hz.StallCycles === got.sc) else begin
      errors++;
      $error("FAIL stallcnt t=%0t observed=%0d expected=%0d", $time, hz.StallCycles, got.sc);
    end
    assert (hz.FlushCount === got.fc) else begin
      errors++;
      $error("FAIL flushcnt t=%0t observed=%0d expected=%0d", $time, hz.FlushCount, got.fc);
    end
    @(posedge clk);
    if (!rst) begin
      exp_stall = 0;
      exp_flush = 0;
    end else begin
      if (!ectl[6]) exp_stall++;
      if (ectl[4])  exp_flush++;
    end
    @(negedge clk);
  endtask

  task automatic idle(input logic [6:0] ectl, input logic [1:0] est);
    step(1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, ectl, est);
  endtask

  task automatic mem(input logic br, input logic mq, input logic my,
                     input logic [6:0] ectl, input logic [1:0] est);
    step(1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, br, mq, my, ectl, est);
  endtask

  initial begin
    reset = 1'b0;
    {hz.MemReadEX, hz.Use1ID, hz.Use2ID, hz.BranchTakenEX, hz.MemReqM, hz.MemReadyM} = 6'b000000;
    {hz.WriteRegAddrEX, hz.Reg1AddrID, hz.Reg2AddrID} = 15'd0;
    repeat (2) @(posedge clk);
    @(negedge clk);

    step(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, RST, 2'd0);
    idle(OK, 2'd0);

    // load x5, ID rs1=x5: one bubble; held inputs ignored in LOAD_STALL
    step(1'b1, 1'b1, 5'd5, 5'd5, 5'd3, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, LU, 2'd0);
    step(1'b1, 1'b1, 5'd5, 5'd5, 5'd3, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, OK, 2'd1);
    idle(OK, 2'd0);

    // load to x0 never stalls
    step(1'b1, 1'b1, 5'd0, 5'd0, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, OK, 2'd0);
    // rs1 matches but unused; then rs2 match
    step(1'b1, 1'b1, 5'd7, 5'd7, 5'd2, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, OK, 2'd0);
    step(1'b1, 1'b1, 5'd7, 5'd1, 5'd7, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, LU, 2'd0);
    idle(OK, 2'd1);

    // branch beats load-use
    step(1'b1, 1'b1, 5'd9, 5'd9, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, BR, 2'd0);
    idle(OK, 2'd0);

    // memory not ready for 4 cycles
    mem(1'b0, 1'b1, 1'b0, FRZ, 2'd0);
    for (int i = 0; i < 3; i++) mem(1'b0, 1'b1, 1'b0, FRZ, 2'd2);
    mem(1'b0, 1'b1, 1'b1, OK, 2'd2);
    idle(OK, 2'd0);

    // memstall beats branch; held branch serviced after the wait
    mem(1'b1, 1'b1, 1'b0, FRZ, 2'd0);
    mem(1'b1, 1'b1, 1'b0, FRZ, 2'd2);
    mem(1'b1, 1'b1, 1'b1, OK, 2'd2);
    mem(1'b1, 1'b0, 1'b0, BR, 2'd0);
    idle(OK, 2'd0);

    // memstall arriving during LOAD_STALL
    step(1'b1, 1'b1, 5'd5, 5'd5, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, LU, 2'd0);
    mem(1'b0, 1'b1, 1'b0, FRZ, 2'd1);
    mem(1'b0, 1'b1, 1'b1, OK, 2'd2);
    idle(OK, 2'd0);

    // ready never rises: forced release in the 15th MEM_WAIT cycle
    mem(1'b0, 1'b1, 1'b0, FRZ, 2'd0);
    for (int i = 0; i < 14; i++) mem(1'b0, 1'b1, 1'b0, FRZ, 2'd2);
    mem(1'b0, 1'b1, 1'b0, TO, 2'd2);
    mem(1'b0, 1'b1, 1'b0, FRZ, 2'd0);
    mem(1'b0, 1'b1, 1'b0, FRZ, 2'd2);
    mem(1'b0, 1'b1, 1'b0, FRZ, 2'd2);

    // reset in the middle of MEM_WAIT
    step(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, RST, 2'd2);
    step(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, RST, 2'd0);
    idle(OK, 2'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
